taxi_baser_tx_gearbox_66_64: RTL and testbench
==============================================

# taxi_baser_tx_gearbox_66_64

10GBASE-R transmit scrambler and 66:64 gearbox; sits directly downstream of the 64-bit BASE-R frame transmitter operating in gearbox-interface mode. It scrambles each 64-bit block payload and leaves the 2-bit sync header unscrambled. It packs 32 66-bit blocks into 33 64-bit SERDES words and paces the upstream transmitter with the gearbox request-sync and request-stall strobes.

## Interface
- `SCRAMBLER_EN`, default 1: enables the x^58+x^39+1 self-synchronous scrambler on data bits; 0 passes data through unchanged.
- `SCRAMBLER_INIT`, default 58'h3ff_ffff_ffff_ffff: scrambler state at reset.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `encoded_tx_data`  in  64  block payload, bit 0 transmitted first.
- `encoded_tx_data_valid`  in  1  payload valid.
- `encoded_tx_hdr`  in  2  sync header: 2'b01 data, 2'b10 control.
- `encoded_tx_hdr_valid`  in  1  header valid; must equal `encoded_tx_data_valid`.
- `tx_gbx_sync`  in  1  marks the input block upstream intends as block 0 of a sequence.
- `tx_gbx_req_sync`  out  1  one-cycle pulse requesting that the next accepted block be block 0.
- `tx_gbx_req_stall`  out  1  asserted one cycle ahead of the stall slot.
- `serdes_tx_data`  out  64  gearbox output word, bit 0 first.
- `serdes_tx_data_valid`  out  1  output word valid.
- `stat_tx_gbx_underflow`  out  1  pulse: an idle block was inserted.
- `stat_tx_gbx_overrun`  out  1  pulse: a block arrived in the stall slot and was dropped.
- `stat_tx_gbx_sync_err`  out  1  pulse: `tx_gbx_sync` disagrees with the internal sequence.

## Operation
- Sequence counter `seq`, range 0..32, wraps 32→0. It advances every cycle after reset.
- Slots 0..31 are input slots, and one 66-bit block is consumed in each. Slot 32 is the stall slot, and no block is consumed.
- Block is {data, hdr}: hdr occupies bits [1:0] and is transmitted first; data occupies bits [65:2].
- Pack buffer is 130 bits with a fill count. After slot k (k = 0..31) the residual is 2(k+1) bits. Slot 32 emits the 64 residual bits, and the residual returns to 0.
- `tx_gbx_req_stall` = 1 when `seq` == 31, i.e. in the cycle before the stall slot.
- `tx_gbx_req_sync` = 1 when `seq` == 32, i.e. in the cycle before slot 0.
- Underflow: valid low in an input slot. The block {64'h0000_0000_0000_001e, 2'b10} (idle control block) is inserted and scrambled normally; `stat_tx_gbx_underflow` pulses.
- Overrun: valid high in the stall slot. The block is discarded, the scrambler does not advance, and `stat_tx_gbx_overrun` pulses.
- `tx_gbx_sync` high with `seq` != 0 in an input slot, or low with `seq` == 0 while valid: `stat_tx_gbx_sync_err` pulses. Behaviour is otherwise unchanged; the internal count is authoritative.
- Scrambler: out[i] = in[i] ^ s[i-39] ^ s[i-58] over the serial bit stream. State updates only on consumed blocks, including inserted idles.
- `encoded_tx_hdr_valid` is ignored except through equality with `encoded_tx_data_valid`; a mismatch is treated as valid low.

## Timing
- Stage 1 registers the scrambled block, seq tag and flags. Stage 2 registers the gearbox output word. Input-to-output latency is 2 cycles for the first bits of a block.
- Reset values:
  - `seq` = 0, buffer fill = 0, scrambler = `SCRAMBLER_INIT`.
  - All outputs 0, including `serdes_tx_data` = 0 and `serdes_tx_data_valid` = 0.
- First cycle after `rst` deasserts is slot 0. `serdes_tx_data_valid` first asserts 2 cycles later and then stays high every cycle until reset.
- Stat pulses are aligned with stage 1, i.e. 1 cycle after the offending input cycle.
- Reset mid-sequence: everything returns to reset values on the next edge, and the partial buffer is discarded.
- Output cadence is exactly 33 words per 32 blocks, with no gaps.

## Structure
- The `taxi_baser_pkg` shared package holds:
  - header constants BASER_SYNC_DATA = 2'b01 and BASER_SYNC_CTRL = 2'b10;
  - BASER_BLOCK_TYPE_CTRL = 8'h1e;
  - the scrambler polynomial taps 39 and 58.
- Sub-module `taxi_baser_scrambler_64` holds the 64-bit-parallel scrambler with an enable, a registered output and a state register. The gearbox logic stays in the top module.

## Test plan
- SCRAMBLER_EN=0, continuous data blocks honouring req_stall, each data = {seq, 56'h0}, hdr 01 → the descrambled, ungeared 66-bit stream matches the input. `req_stall` is high every 33rd cycle (seq 31) and `req_sync` at seq 32.
- SCRAMBLER_EN=1, fixed input all-zero data blocks → output matches a reference LFSR model seeded with 58'h3ff_ffff_ffff_ffff. The 2-bit headers remain at offset 66n in the bit stream.
- Valid deasserted in slot 5 → the idle block 0x1e/hdr 10 appears in the stream, `stat_tx_gbx_underflow` pulses once, and the cadence is unchanged.
- Valid asserted in stall slot 32 → the block is absent from the output, `stat_tx_gbx_overrun` pulses, and subsequent scrambler output is continuous.
- `tx_gbx_sync` asserted at seq 3 → one `stat_tx_gbx_sync_err` pulse; the data path is unaffected.
- Reset asserted at seq 17 for 1 cycle → outputs zero with valid low, the next cycle is slot 0, and the first output equals the post-reset reference.

Source files
------------

// File: rtl/taxi_baser_pkg.sv
// taxi_baser_pkg: shared BASE-R sync header, block type and scrambler tap constants
package taxi_baser_pkg;
    localparam logic [1:0] BASER_SYNC_DATA = 2'b01;
    localparam logic [1:0] BASER_SYNC_CTRL = 2'b10;
    localparam logic [7:0] BASER_BLOCK_TYPE_CTRL = 8'h1e;
    localparam logic [63:0] BASER_IDLE_DATA = {56'd0, BASER_BLOCK_TYPE_CTRL};
    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;
    localparam logic [5:0] GBX_SEQ_STALL = 6'd32;
endpackage

// File: rtl/taxi_baser_tx_gearbox_66_64_if.sv
// taxi_baser_tx_gearbox_66_64_if: encoded block input, gearbox pacing strobes and SERDES output
interface taxi_baser_tx_gearbox_66_64_if;
    logic [63:0] encoded_tx_data;
    logic        encoded_tx_data_valid;
    logic [1:0]  encoded_tx_hdr;
    logic        encoded_tx_hdr_valid;
    logic        tx_gbx_sync;
    logic        tx_gbx_req_sync;
    logic        tx_gbx_req_stall;
    logic [63:0] serdes_tx_data;
    logic        serdes_tx_data_valid;
    logic        stat_tx_gbx_underflow;
    logic        stat_tx_gbx_overrun;
    logic        stat_tx_gbx_sync_err;

    modport master (
        output encoded_tx_data, encoded_tx_data_valid, encoded_tx_hdr, encoded_tx_hdr_valid, tx_gbx_sync,
        input  tx_gbx_req_sync, tx_gbx_req_stall, serdes_tx_data, serdes_tx_data_valid,
        input  stat_tx_gbx_underflow, stat_tx_gbx_overrun, stat_tx_gbx_sync_err
    );
    modport slave (
        input  encoded_tx_data, encoded_tx_data_valid, encoded_tx_hdr, encoded_tx_hdr_valid, tx_gbx_sync,
        output tx_gbx_req_sync, tx_gbx_req_stall, serdes_tx_data, serdes_tx_data_valid,
        output stat_tx_gbx_underflow, stat_tx_gbx_overrun, stat_tx_gbx_sync_err
    );
endinterface

// File: rtl/taxi_baser_scrambler_64.sv
// taxi_baser_scrambler_64: 64-bit parallel x^58+x^39+1 self-synchronous scrambler, registered output
module taxi_baser_scrambler_64
    import taxi_baser_pkg::*;
#(
    parameter bit          ENABLE = 1'b1,
    parameter logic [57:0] INIT   = 58'h3ff_ffff_ffff_ffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] din,
    output logic [63:0] dout
);
    logic [57:0]  state_q, state_d;
    logic [63:0]  dout_q, dout_d;
    logic [121:0] ext;

    // ext[57:0] is the history (ext[57] newest); ext[58+i] becomes scrambled bit i
    always_comb begin
        ext = {din, state_q};
        for (int i = 0; i < 64; i++)
            ext[58+i] = din[i] ^ ext[58+i-SCR_TAP_A] ^ ext[58+i-SCR_TAP_B];
        dout_d = ENABLE ? ext[121:58] : din;
        state_d = en ? ext[121:64] : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            dout_q <= 64'd0;
        end else begin
            state_q <= state_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/taxi_baser_tx_gearbox_66_64.sv
// taxi_baser_tx_gearbox_66_64: BASE-R TX scrambler plus 66:64 gearbox, 32 blocks into 33 words
module taxi_baser_tx_gearbox_66_64
    import taxi_baser_pkg::*;
#(
    parameter bit          SCRAMBLER_EN   = 1'b1,
    parameter logic [57:0] SCRAMBLER_INIT = 58'h3ff_ffff_ffff_ffff
) (
    input  logic clk,
    input  logic rst,
    taxi_baser_tx_gearbox_66_64_if.slave bus
);
    logic [5:0]   seq_q, seq_d, s1_tag_q, s1_tag_d;
    logic [1:0]   s1_hdr_q, s1_hdr_d;
    logic         s1_valid_q, s1_valid_d, uf_q, uf_d, ov_q, ov_d, se_q, se_d;
    logic         in_valid, consume, stall;
    logic [63:0]  blk_data, s1_data, res_q, res_d, out_q, out_d;
    logic [6:0]   fill_q, fill_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] cat;

    always_comb begin
        in_valid = bus.encoded_tx_data_valid && bus.encoded_tx_hdr_valid;
        consume = seq_q != GBX_SEQ_STALL;
        seq_d = consume ? seq_q + 6'd1 : 6'd0;
        blk_data = in_valid ? bus.encoded_tx_data : BASER_IDLE_DATA;
        s1_hdr_d = in_valid ? bus.encoded_tx_hdr : BASER_SYNC_CTRL;
        s1_tag_d = seq_q;
        s1_valid_d = 1'b1;
        uf_d = consume && !in_valid;
        ov_d = !consume && in_valid;
        se_d = consume && (bus.tx_gbx_sync ? seq_q != 6'd0 : (seq_q == 6'd0 && in_valid));
    end

    taxi_baser_scrambler_64 #(
        .ENABLE(SCRAMBLER_EN),
        .INIT  (SCRAMBLER_INIT)
    ) u_scr (
        .clk (clk),
        .rst (rst),
        .en  (consume),
        .din (blk_data),
        .dout(s1_data)
    );

    // residual occupies the low fill_q bits; the new block lands directly above it
    always_comb begin
        cat = ({62'd0, s1_data, s1_hdr_q} << fill_q) | {64'd0, res_q};
        stall = s1_tag_q == GBX_SEQ_STALL;
        out_d = !s1_valid_q ? 64'd0 : stall ? res_q : cat[63:0];
        res_d = !s1_valid_q ? res_q : stall ? 64'd0 : cat[127:64];
        fill_d = !s1_valid_q ? fill_q : stall ? 7'd0 : fill_q + 7'd2;
        out_valid_d = s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= 6'd0;
            s1_tag_q <= 6'd0;
            s1_hdr_q <= 2'd0;
            s1_valid_q <= 1'b0;
            uf_q <= 1'b0;
            ov_q <= 1'b0;
            se_q <= 1'b0;
            res_q <= 64'd0;
            fill_q <= 7'd0;
            out_q <= 64'd0;
            out_valid_q <= 1'b0;
        end else begin
            seq_q <= seq_d;
            s1_tag_q <= s1_tag_d;
            s1_hdr_q <= s1_hdr_d;
            s1_valid_q <= s1_valid_d;
            uf_q <= uf_d;
            ov_q <= ov_d;
            se_q <= se_d;
            res_q <= res_d;
            fill_q <= fill_d;
            out_q <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.tx_gbx_req_stall = seq_q == GBX_SEQ_STALL - 6'd1;
    assign bus.tx_gbx_req_sync = seq_q == GBX_SEQ_STALL;
    assign bus.serdes_tx_data = out_q;
    assign bus.serdes_tx_data_valid = out_valid_q;
    assign bus.stat_tx_gbx_underflow = uf_q;
    assign bus.stat_tx_gbx_overrun = ov_q;
    assign bus.stat_tx_gbx_sync_err = se_q;
endmodule

// File: tb/tb_taxi_baser_tx_gearbox_66_64.sv
// tb_taxi_baser_tx_gearbox_66_64: bit-stream scoreboard for unscrambled and scrambled gearbox instances
module tb_taxi_baser_tx_gearbox_66_64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    bit q0[$];
    bit q1[$];
    logic [57:0] hist = '1;
    int mon_seq = 0;
    int n_run = 0;
    logic pend_uf = 1'b0, pend_ov = 1'b0, pend_se = 1'b0;
    int uf_cnt = 0, ov_cnt = 0, se_cnt = 0;

    taxi_baser_tx_gearbox_66_64_if bus0();
    taxi_baser_tx_gearbox_66_64_if bus1();

    taxi_baser_tx_gearbox_66_64 #(.SCRAMBLER_EN(1'b0), .SCRAMBLER_INIT(58'h3ff_ffff_ffff_ffff))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    taxi_baser_tx_gearbox_66_64 #(.SCRAMBLER_EN(1'b1), .SCRAMBLER_INIT(58'h3ff_ffff_ffff_ffff))
        u1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) begin : monitor
        logic [63:0] e0, e1;
        #1;
        if (rst) begin
            checks++;
            if (bus0.serdes_tx_data_valid !== 1'b0 || bus1.serdes_tx_data_valid !== 1'b0 ||
                bus0.serdes_tx_data !== 64'd0 || bus1.serdes_tx_data !== 64'd0) begin
                errors++;
                $display("FAIL reset_out got v=%b/%b d=%h/%h want 0", bus0.serdes_tx_data_valid,
                         bus1.serdes_tx_data_valid, bus0.serdes_tx_data, bus1.serdes_tx_data);
            end
            q0.delete();
            q1.delete();
            hist = '1;
            mon_seq = 0;
            n_run = 0;
        end else begin
            mon_seq = (mon_seq == 32) ? 0 : mon_seq + 1;
            n_run++;
            checks++;
            if (bus0.serdes_tx_data_valid !== (n_run >= 2) || bus1.serdes_tx_data_valid !== (n_run >= 2)) begin
                errors++;
                $display("FAIL out_valid got %b/%b want %b", bus0.serdes_tx_data_valid,
                         bus1.serdes_tx_data_valid, n_run >= 2);
            end
            checks++;
            if ({bus1.tx_gbx_req_stall, bus1.tx_gbx_req_sync} !== {mon_seq == 31, mon_seq == 32} ||
                {bus0.tx_gbx_req_stall, bus0.tx_gbx_req_sync} !== {mon_seq == 31, mon_seq == 32}) begin
                errors++;
                $display("FAIL req got stall/sync %b%b want %b%b (seq %0d)", bus1.tx_gbx_req_stall,
                         bus1.tx_gbx_req_sync, mon_seq == 31, mon_seq == 32, mon_seq);
            end
            checks++;
            if ({bus1.stat_tx_gbx_underflow, bus1.stat_tx_gbx_overrun, bus1.stat_tx_gbx_sync_err} !== {pend_uf, pend_ov, pend_se} ||
                {bus0.stat_tx_gbx_underflow, bus0.stat_tx_gbx_overrun, bus0.stat_tx_gbx_sync_err} !== {pend_uf, pend_ov, pend_se}) begin
                errors++;
                $display("FAIL stats got uf/ov/se %b%b%b want %b%b%b", bus1.stat_tx_gbx_underflow,
                         bus1.stat_tx_gbx_overrun, bus1.stat_tx_gbx_sync_err, pend_uf, pend_ov, pend_se);
            end
            uf_cnt += int'(bus1.stat_tx_gbx_underflow === 1'b1);
            ov_cnt += int'(bus1.stat_tx_gbx_overrun === 1'b1);
            se_cnt += int'(bus1.stat_tx_gbx_sync_err === 1'b1);
            if (n_run >= 2) begin
                checks++;
                if (q0.size() < 64 || q1.size() < 64) begin
                    errors++;
                    $display("FAIL scoreboard_empty got %0d/%0d bits want 64", q0.size(), q1.size());
                end else begin
                    for (int i = 0; i < 64; i++) begin
                        e0[i] = q0.pop_front();
                        e1[i] = q1.pop_front();
                    end
                    if (bus0.serdes_tx_data !== e0) begin
                        errors++;
                        $display("FAIL word_raw got %h want %h", bus0.serdes_tx_data, e0);
                    end
                    checks++;
                    if (bus1.serdes_tx_data !== e1) begin
                        errors++;
                        $display("FAIL word_scr got %h want %h", bus1.serdes_tx_data, e1);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic hv, input logic [63:0] data, input logic [1:0] hdr, input logic sync);
        logic in_v, cons, o;
        logic [63:0] bd;
        logic [1:0] bh;
        rst = 1'b0;
        bus0.encoded_tx_data = data;       bus1.encoded_tx_data = data;
        bus0.encoded_tx_data_valid = v;    bus1.encoded_tx_data_valid = v;
        bus0.encoded_tx_hdr = hdr;         bus1.encoded_tx_hdr = hdr;
        bus0.encoded_tx_hdr_valid = hv;    bus1.encoded_tx_hdr_valid = hv;
        bus0.tx_gbx_sync = sync;           bus1.tx_gbx_sync = sync;
        in_v = v && hv;
        cons = mon_seq != 32;
        pend_uf = cons && !in_v;
        pend_ov = !cons && in_v;
        pend_se = cons && (sync ? mon_seq != 0 : (mon_seq == 0 && in_v));
        if (cons) begin
            bd = in_v ? data : 64'h0000_0000_0000_001e;
            bh = in_v ? hdr : 2'b10;
            for (int i = 0; i < 2; i++) begin
                q0.push_back(bh[i]);
                q1.push_back(bh[i]);
            end
            for (int i = 0; i < 64; i++) begin
                o = bd[i] ^ hist[38] ^ hist[57];
                hist = {hist[56:0], o};
                q0.push_back(bd[i]);
                q1.push_back(o);
            end
        end
    endtask

    task automatic tick(output int s);
        @(negedge clk);
        s = mon_seq;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pend_uf = 1'b0; pend_ov = 1'b0; pend_se = 1'b0;
        bus0.encoded_tx_data = '0;      bus1.encoded_tx_data = '0;
        bus0.encoded_tx_data_valid = 0; bus1.encoded_tx_data_valid = 0;
        bus0.encoded_tx_hdr = '0;       bus1.encoded_tx_hdr = '0;
        bus0.encoded_tx_hdr_valid = 0;  bus1.encoded_tx_hdr_valid = 0;
        bus0.tx_gbx_sync = 0;           bus1.tx_gbx_sync = 0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({bus1.tx_gbx_req_stall, bus1.tx_gbx_req_sync, bus1.stat_tx_gbx_underflow, bus1.stat_tx_gbx_overrun,
             bus1.stat_tx_gbx_sync_err, bus1.serdes_tx_data_valid} !== 6'b0 || bus1.serdes_tx_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_state got flags %b%b%b%b%b%b data %h want all 0", bus1.tx_gbx_req_stall,
                     bus1.tx_gbx_req_sync, bus1.stat_tx_gbx_underflow, bus1.stat_tx_gbx_overrun,
                     bus1.stat_tx_gbx_sync_err, bus1.serdes_tx_data_valid, bus1.serdes_tx_data);
        end
    endtask

    task automatic test_data_stream();
        int s, uf0, ov0, se0;
        uf0 = uf_cnt; ov0 = ov_cnt; se0 = se_cnt;
        repeat (66) begin
            tick(s);
            drive(s != 32, s != 32, {8'(s), 56'h0}, 2'b01, s == 0);
        end
        checks++;
        if (uf_cnt != uf0 || ov_cnt != ov0 || se_cnt != se0) begin
            errors++;
            $display("FAIL stream_stats got uf/ov/se %0d/%0d/%0d want 0/0/0", uf_cnt - uf0, ov_cnt - ov0, se_cnt - se0);
        end
    endtask

    task automatic test_zero_blocks();
        int s;
        repeat (40) begin
            tick(s);
            drive(s != 32, s != 32, 64'd0, 2'b01, s == 0);
        end
    endtask

    task automatic test_underflow();
        int s, uf0;
        bit hit5 = 0, hit9 = 0;
        uf0 = uf_cnt;
        repeat (45) begin
            tick(s);
            if (s == 5 && !hit5) begin
                hit5 = 1;
                drive(1'b0, 1'b0, 64'($urandom), 2'b01, 1'b0);
            end else if (s == 9 && !hit9) begin
                hit9 = 1;
                drive(1'b1, 1'b0, {$urandom, $urandom}, 2'b01, 1'b0);
            end else begin
                drive(s != 32, s != 32, {$urandom, $urandom}, (s % 4 == 1) ? 2'b10 : 2'b01, s == 0);
            end
        end
        checks++;
        if (uf_cnt - uf0 != 2) begin
            errors++;
            $display("FAIL underflow_count got %0d want 2", uf_cnt - uf0);
        end
    endtask

    task automatic test_overrun();
        int s, ov0;
        bit hit = 0;
        ov0 = ov_cnt;
        repeat (45) begin
            tick(s);
            drive(s != 32 || !hit, s != 32 || !hit, {$urandom, $urandom}, 2'b01, s == 0);
            if (s == 32) hit = 1;
        end
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_count got %0d want 1", ov_cnt - ov0);
        end
    endtask

    task automatic test_sync_err();
        int s, se0;
        bit hit = 0;
        se0 = se_cnt;
        repeat (45) begin
            tick(s);
            drive(s != 32, s != 32, {$urandom, $urandom}, 2'b01, s == 0 || (s == 3 && !hit));
            if (s == 3) hit = 1;
        end
        checks++;
        if (se_cnt - se0 != 1) begin
            errors++;
            $display("FAIL sync_err_count got %0d want 1", se_cnt - se0);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        bit hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            tick(s);
            if (s == 17) begin
                hit = 1;
                rst = 1'b1;
                pend_uf = 1'b0; pend_ov = 1'b0; pend_se = 1'b0;
            end else begin
                drive(s != 32, s != 32, {$urandom, $urandom}, 2'b01, s == 0);
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach got no seq 17 want seq 17 within 40 cycles");
        end
        @(posedge clk);
        #2;
        checks++;
        if (bus1.serdes_tx_data_valid !== 1'b0 || bus1.serdes_tx_data !== 64'd0 || bus0.serdes_tx_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_out got v=%b d=%h want v=0 d=0", bus1.serdes_tx_data_valid, bus1.serdes_tx_data);
        end
        repeat (40) begin
            tick(s);
            drive(s != 32, s != 32, {$urandom, $urandom}, 2'b01, s == 0);
        end
    endtask

    initial begin
        test_reset();
        test_data_stream();
        test_zero_blocks();
        test_underflow();
        test_overrun();
        test_sync_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
